// File: rtl/map_table_pkg.sv
// map_table_pkg: shared sizes and packet types for the rename map table and free list
package map_table_pkg;

    localparam int N_DEF       = 3;
    localparam int ARCH_REG_SZ = 32;
    localparam int ROB_SZ      = 32;
    localparam int PHYS_REG_SZ = ARCH_REG_SZ + ROB_SZ;
    localparam int PREG_W      = $clog2(PHYS_REG_SZ);

    typedef struct packed {
        logic [PREG_W-1:0] preg;
        logic              ready;
    } MAP_TABLE_PACKET;

    typedef struct packed {
        logic [PREG_W-1:0] reg_idx;
    } FREE_LIST_PACKET;

endpackage

// File: rtl/map_table_fwd.sv
// map_table_fwd: finds the highest earlier writer slot (below SLOT) whose destination matches areg
module map_table_fwd #(
    parameter int N    = 3,
    parameter int AW   = 5,
    parameter int SLOT = 0,
    localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic [AW-1:0]         areg,
    input  logic [N-1:0]          wr,
    input  logic [N-1:0][AW-1:0]  dest,
    output logic                  hit,
    output logic [IW-1:0]         idx
);

    // ascending scan so the last (highest) matching slot overwrites earlier ones
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < SLOT; i++) begin
            if (wr[i] && dest[i] == areg) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/map_table.sv
// map_table: speculative N-wide register rename map with CDB wakeup and one-cycle branch restore.
// Optional MAP_TABLE_CDB_BYPASS_EN: sources whose preg is on the CDB this cycle report ready.
module map_table
    import map_table_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int ARCH_REGS = ARCH_REG_SZ,
    parameter int PHYS_REGS = PHYS_REG_SZ,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS),
    localparam int CW = $clog2(N + 1),
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [N-1:0]                  rn_valid,
    input  logic [N-1:0][AW-1:0]          rn_src1,
    input  logic [N-1:0][AW-1:0]          rn_src2,
    input  logic [N-1:0][AW-1:0]          rn_dest,
    input  logic [N-1:0]                  rn_has_dest,
    input  FREE_LIST_PACKET [N-1:0]       fl_reg,
    output logic [CW-1:0]                 fl_rd_num,
    output logic [N-1:0][PW-1:0]          src1_preg,
    output logic [N-1:0][PW-1:0]          src2_preg,
    output logic [N-1:0]                  src1_ready,
    output logic [N-1:0]                  src2_ready,
    output logic [N-1:0][PW-1:0]          dest_preg,
    output logic [N-1:0][PW-1:0]          dest_old_preg,
    input  logic [N-1:0]                  cdb_valid,
    input  logic [N-1:0][PW-1:0]          cdb_preg,
    input  logic                          restore_en,
    input  logic [ARCH_REGS-1:0][PW-1:0]  restore_map
);

`ifdef MAP_TABLE_CDB_BYPASS_EN
    localparam bit CDB_BYP = 1'b1;
`else
    localparam bit CDB_BYP = 1'b0;
`endif

    MAP_TABLE_PACKET           table_q [ARCH_REGS];
    MAP_TABLE_PACKET           table_d [ARCH_REGS];
    logic [N-1:0]              wr;
    logic [N-1:0][PW-1:0]      alloc;
    logic [CW-1:0]             wr_cnt;
    logic [N-1:0]              h1, h2, ho;
    logic [N-1:0][IW-1:0]      i1, i2, io;

    function automatic logic on_cdb(input logic [PW-1:0] p, input logic [N-1:0] v,
                                    input logic [N-1:0][PW-1:0] c);
        on_cdb = 1'b0;
        for (int i = 0; i < N; i++) on_cdb = on_cdb || (v[i] && c[i] == p);
    endfunction

    // r0 writes are dropped; the k-th real writer takes the k-th free-list entry
    always_comb begin
        wr     = '0;
        alloc  = '0;
        wr_cnt = '0;
        for (int i = 0; i < N; i++) begin
            wr[i] = rn_valid[i] && rn_has_dest[i] && rn_dest[i] != '0;
            if (wr[i]) begin
                alloc[i] = PW'(fl_reg[wr_cnt].reg_idx);
                wr_cnt   = wr_cnt + 1'b1;
            end
        end
    end

    assign fl_rd_num = (!reset_n || restore_en) ? '0 : wr_cnt;

    for (genvar j = 0; j < N; j++) begin : g_slot
        map_table_fwd #(.N(N), .AW(AW), .SLOT(j)) u_fwd_s1 (
            .areg(rn_src1[j]), .wr(wr), .dest(rn_dest), .hit(h1[j]), .idx(i1[j]));
        map_table_fwd #(.N(N), .AW(AW), .SLOT(j)) u_fwd_s2 (
            .areg(rn_src2[j]), .wr(wr), .dest(rn_dest), .hit(h2[j]), .idx(i2[j]));
        map_table_fwd #(.N(N), .AW(AW), .SLOT(j)) u_fwd_old (
            .areg(rn_dest[j]), .wr(wr), .dest(rn_dest), .hit(ho[j]), .idx(io[j]));
    end

    // lookups prefer an earlier same-bundle writer (not yet ready) over the table
    always_comb begin
        for (int j = 0; j < N; j++) begin
            src1_preg[j]     = h1[j] ? alloc[i1[j]] : PW'(table_q[rn_src1[j]].preg);
            src2_preg[j]     = h2[j] ? alloc[i2[j]] : PW'(table_q[rn_src2[j]].preg);
            src1_ready[j]    = (!h1[j] && table_q[rn_src1[j]].ready) ||
                               (CDB_BYP && on_cdb(src1_preg[j], cdb_valid, cdb_preg));
            src2_ready[j]    = (!h2[j] && table_q[rn_src2[j]].ready) ||
                               (CDB_BYP && on_cdb(src2_preg[j], cdb_valid, cdb_preg));
            dest_preg[j]     = alloc[j];
            dest_old_preg[j] = !wr[j] ? '0 : ho[j] ? alloc[io[j]] : PW'(table_q[rn_dest[j]].preg);
        end
    end

    // next table: CDB wakeup, then renames in slot order, all overridden by restore
    always_comb begin
        for (int a = 0; a < ARCH_REGS; a++) begin
            table_d[a] = table_q[a];
            if (on_cdb(PW'(table_q[a].preg), cdb_valid, cdb_preg)) table_d[a].ready = 1'b1;
        end
        for (int i = 0; i < N; i++)
            if (wr[i]) table_d[rn_dest[i]] = '{preg: PREG_W'(alloc[i]), ready: 1'b0};
        if (restore_en)
            for (int a = 0; a < ARCH_REGS; a++)
                table_d[a] = '{preg: PREG_W'(restore_map[a]), ready: 1'b1};
    end

    // reset maps each architectural register to the physical register of the same index
    always_ff @(posedge clock) begin
        if (!reset_n)
            for (int a = 0; a < ARCH_REGS; a++) table_q[a] <= '{preg: PREG_W'(a), ready: 1'b1};
        else
            table_q <= table_d;
    end

endmodule

// File: tb/tb_map_table.sv
// tb_map_table: directed and randomized checks of map_table against a sequential rename model
module tb_map_table;
    import map_table_pkg::*;

    localparam int N = 3, A = 32, AW = 5, PW = 6;
`ifdef MAP_TABLE_CDB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic [N-1:0]           rn_valid, rn_has_dest, cdb_valid;
    logic [N-1:0][AW-1:0]   rn_src1, rn_src2, rn_dest;
    FREE_LIST_PACKET [N-1:0] fl_reg;
    logic [1:0]             fl_rd_num;
    logic [N-1:0][PW-1:0]   src1_preg, src2_preg, dest_preg, dest_old_preg, cdb_preg;
    logic [N-1:0]           src1_ready, src2_ready;
    logic                   restore_en;
    logic [A-1:0][PW-1:0]   restore_map;

    int m_preg[A];
    int m_rdy[A];
    int vectors = 0;
    int errs = 0;

    map_table dut (
        .clock(clock), .reset_n(reset_n), .rn_valid(rn_valid), .rn_src1(rn_src1),
        .rn_src2(rn_src2), .rn_dest(rn_dest), .rn_has_dest(rn_has_dest), .fl_reg(fl_reg),
        .fl_rd_num(fl_rd_num), .src1_preg(src1_preg), .src2_preg(src2_preg),
        .src1_ready(src1_ready), .src2_ready(src2_ready), .dest_preg(dest_preg),
        .dest_old_preg(dest_old_preg), .cdb_valid(cdb_valid), .cdb_preg(cdb_preg),
        .restore_en(restore_en), .restore_map(restore_map));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    function automatic bit writer(input int j);
        return rn_valid[j] && rn_has_dest[j] && rn_dest[j] != 0;
    endfunction

    function automatic bit cdb_has(input int p);
        for (int i = 0; i < N; i++) if (cdb_valid[i] && cdb_preg[i] == p) return 1;
        return 0;
    endfunction

    task automatic idle();
        rn_valid = '0; rn_has_dest = '0; rn_src1 = '0; rn_src2 = '0; rn_dest = '0;
        cdb_valid = '0; cdb_preg = '0; restore_en = 1'b0; fl_reg = '0;
    endtask

    // rename the bundle one slot at a time against a working copy of the map
    task automatic eval();
        int wp[A];
        int wrd[A];
        int k;
        #1;
        wp = m_preg; wrd = m_rdy; k = 0;
        if (!reset_n || restore_en) begin
            chk("rd_num_squash", 32'(fl_rd_num), 0);
            return;
        end
        for (int j = 0; j < N; j++) begin
            if (rn_valid[j]) begin
                chk($sformatf("src1_preg[%0d]", j), 32'(src1_preg[j]), wp[rn_src1[j]]);
                chk($sformatf("src1_rdy[%0d]", j), 32'(src1_ready[j]),
                    32'(wrd[rn_src1[j]] | (BYP & int'(cdb_has(wp[rn_src1[j]])))));
                chk($sformatf("src2_preg[%0d]", j), 32'(src2_preg[j]), wp[rn_src2[j]]);
                chk($sformatf("src2_rdy[%0d]", j), 32'(src2_ready[j]),
                    32'(wrd[rn_src2[j]] | (BYP & int'(cdb_has(wp[rn_src2[j]])))));
            end
            if (writer(j)) begin
                chk($sformatf("dest[%0d]", j), 32'(dest_preg[j]), 32'(fl_reg[k].reg_idx));
                chk($sformatf("old[%0d]", j), 32'(dest_old_preg[j]), wp[rn_dest[j]]);
                wp[rn_dest[j]] = int'(fl_reg[k].reg_idx);
                wrd[rn_dest[j]] = 0;
                k++;
            end else begin
                chk($sformatf("dest_nw[%0d]", j), 32'(dest_preg[j]), 0);
                chk($sformatf("old_nw[%0d]", j), 32'(dest_old_preg[j]), 0);
            end
        end
        chk("rd_num", 32'(fl_rd_num), k);
    endtask

    task automatic commit();
        int np[A];
        int nr[A];
        int k;
        np = m_preg; nr = m_rdy; k = 0;
        if (!reset_n) begin
            for (int a = 0; a < A; a++) begin np[a] = a; nr[a] = 1; end
        end else if (restore_en) begin
            for (int a = 0; a < A; a++) begin np[a] = int'(restore_map[a]); nr[a] = 1; end
        end else begin
            for (int a = 0; a < A; a++) if (cdb_has(np[a])) nr[a] = 1;
            for (int j = 0; j < N; j++) if (writer(j)) begin
                np[rn_dest[j]] = int'(fl_reg[k].reg_idx);
                nr[rn_dest[j]] = 0;
                k++;
            end
        end
        @(posedge clock);
        m_preg = np; m_rdy = nr;
        @(negedge clock);
    endtask

    initial begin
        idle();
        for (int a = 0; a < A; a++) restore_map[a] = PW'(a + 10);
        // reset with a full bundle presented: it must be discarded
        rn_valid = '1; rn_has_dest = '1; rn_dest = {5'd4, 5'd5, 5'd6};
        eval(); commit();
        reset_n = 1'b1;
        idle(); rn_valid[0] = 1'b1; rn_src1[0] = 5'd5;
        eval();
        chk("reset_r5_preg", 32'(src1_preg[0]), 5);
        chk("reset_r5_rdy", 32'(src1_ready[0]), 1);
        chk("reset_rd_num", 32'(fl_rd_num), 0);
        commit();
        // single rename
        idle(); rn_valid[0] = 1'b1; rn_has_dest[0] = 1'b1; rn_dest[0] = 5'd3; fl_reg[0] = 6'd32;
        eval();
        chk("single_rd_num", 32'(fl_rd_num), 1);
        chk("single_dest", 32'(dest_preg[0]), 32);
        chk("single_old", 32'(dest_old_preg[0]), 3);
        commit();
        idle(); rn_valid[0] = 1'b1; rn_src1[0] = 5'd3;
        eval();
        chk("r3_preg", 32'(src1_preg[0]), 32);
        chk("r3_rdy", 32'(src1_ready[0]), 0);
        commit();
        // intra-bundle forwarding
        idle(); rn_valid = '1; rn_has_dest = 3'b011; rn_dest[0] = 5'd1; rn_dest[1] = 5'd1;
        rn_src1[1] = 5'd1; rn_src1[2] = 5'd1; fl_reg[0] = 6'd40; fl_reg[1] = 6'd41;
        eval();
        chk("fwd_s1_preg", 32'(src1_preg[1]), 40);
        chk("fwd_s1_rdy", 32'(src1_ready[1]), 0);
        chk("fwd_s1_old", 32'(dest_old_preg[1]), 40);
        chk("fwd_s2_preg", 32'(src1_preg[2]), 41);
        chk("fwd_rd_num", 32'(fl_rd_num), 2);
        commit();
        idle(); rn_valid[0] = 1'b1; rn_src1[0] = 5'd1;
        eval();
        chk("fwd_next_r1", 32'(src1_preg[0]), 41);
        commit();
        // CDB wakeup of r3 -> 32
        idle(); rn_valid[0] = 1'b1; rn_src1[0] = 5'd3; cdb_valid[0] = 1'b1; cdb_preg[0] = 6'd32;
        eval();
        chk("cdb_same_rdy", 32'(src1_ready[0]), BYP);
        commit();
        idle(); rn_valid[0] = 1'b1; rn_src1[0] = 5'd3;
        eval();
        chk("cdb_next_rdy", 32'(src1_ready[0]), 1);
        commit();
        // r0 and invalid slots
        idle(); rn_valid = 3'b101; rn_has_dest = '1; rn_dest = {5'd7, 5'd9, 5'd0}; fl_reg[0] = 6'd50;
        eval();
        chk("r0_rd_num", 32'(fl_rd_num), 1);
        chk("r0_dest2", 32'(dest_preg[2]), 50);
        commit();
        idle(); rn_valid[0] = 1'b1; rn_src1[0] = 5'd0; rn_src2[0] = 5'd7;
        eval();
        chk("r0_stays", 32'(src1_preg[0]), 0);
        chk("r7_new", 32'(src2_preg[0]), 50);
        commit();
        // restore concurrent with a rename
        idle(); restore_en = 1'b1; rn_valid[0] = 1'b1; rn_has_dest[0] = 1'b1; rn_dest[0] = 5'd2;
        fl_reg[0] = 6'd60;
        eval();
        chk("restore_rd_num", 32'(fl_rd_num), 0);
        commit();
        idle(); rn_valid[0] = 1'b1; rn_src1[0] = 5'd2;
        eval();
        chk("restore_r2_preg", 32'(src1_preg[0]), 12);
        chk("restore_r2_rdy", 32'(src1_ready[0]), 1);
        commit();
        // randomized bundles with CDB traffic, occasional restore and reset
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int j = 0; j < N; j++) begin
                rn_valid[j] = 1'($urandom_range(0, 3) != 0);
                rn_has_dest[j] = 1'($urandom_range(0, 3) != 0);
                rn_src1[j] = AW'($urandom_range(0, 7));
                rn_src2[j] = AW'($urandom_range(0, 7));
                rn_dest[j] = AW'($urandom_range(0, 7));
                fl_reg[j] = PW'($urandom_range(32, 63));
                cdb_valid[j] = 1'($urandom_range(0, 1));
                cdb_preg[j] = PW'(m_preg[$urandom_range(0, 7)]);
            end
            restore_en = 1'($urandom_range(0, 29) == 0);
            if (restore_en)
                for (int a = 0; a < A; a++) restore_map[a] = PW'($urandom_range(0, 63));
            reset_n = 1'($urandom_range(0, 59) != 0);
            eval(); commit();
            reset_n = 1'b1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
